// File: rtl/arith_unit_alu.sv
// arith_unit_alu: RV32I integer/branch/jump execution stage broadcasting on the Arith CDB
package arith_unit_alu_pkg;
    typedef enum logic [5:0] {
        OP_NOP = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } openum_t;
endpackage

module arith_unit_alu
    import arith_unit_alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  openum_t                 openum_from_rs,
    input  logic [DATA_WIDTH-1:0]   V1_from_rs,
    input  logic [DATA_WIDTH-1:0]   V2_from_rs,
    input  logic [DATA_WIDTH-1:0]   pc_from_rs,
    input  logic [DATA_WIDTH-1:0]   imm_from_rs,
    input  logic [ROB_ID_WIDTH-1:0] rob_id_from_rs,
    input  logic                    misbranch_flag,
    output logic                    valid_to_cdb,
    output logic [ROB_ID_WIDTH-1:0] rob_id_to_cdb,
    output logic [DATA_WIDTH-1:0]   result_to_cdb,
    output logic [DATA_WIDTH-1:0]   target_pc_to_cdb,
    output logic                    jump_flag_to_cdb
);
    localparam int SW = $clog2(DATA_WIDTH);
    logic                  is_imm, is_br, cond;
    logic [DATA_WIDTH-1:0] b, pc4, pc_imm, v1_imm;
    logic [SW-1:0]         sh;
    logic                  nxt_valid, nxt_jump;
    logic [DATA_WIDTH-1:0] nxt_res, nxt_tgt;
    assign is_imm = openum_from_rs inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI};
    assign is_br  = openum_from_rs inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    assign b      = is_imm ? imm_from_rs : V2_from_rs;
    assign sh     = b[SW-1:0];
    assign pc4    = pc_from_rs + DATA_WIDTH'(4);
    assign pc_imm = pc_from_rs + imm_from_rs;
    assign v1_imm = V1_from_rs + imm_from_rs;
    // branch condition evaluated on rs1/rs2 regardless of op; only consumed for branches
    always_comb begin
        cond = 1'b0;
        case (openum_from_rs)
            OP_BEQ:  cond = V1_from_rs == V2_from_rs;
            OP_BNE:  cond = V1_from_rs != V2_from_rs;
            OP_BLT:  cond = $signed(V1_from_rs) < $signed(V2_from_rs);
            OP_BGE:  cond = $signed(V1_from_rs) >= $signed(V2_from_rs);
            OP_BLTU: cond = V1_from_rs < V2_from_rs;
            OP_BGEU: cond = V1_from_rs >= V2_from_rs;
            default: cond = 1'b0;
        endcase
    end
    // next CDB payload; unrecognised ops and NOP leave everything at zero
    always_comb begin
        nxt_valid = 1'b1;
        nxt_res   = '0;
        nxt_tgt   = '0;
        nxt_jump  = 1'b0;
        case (openum_from_rs)
            OP_LUI:            nxt_res = imm_from_rs;
            OP_AUIPC:          nxt_res = pc_imm;
            OP_JAL: begin
                nxt_res  = pc4;
                nxt_tgt  = pc_imm;
                nxt_jump = 1'b1;
            end
            OP_JALR: begin
                nxt_res  = pc4;
                nxt_tgt  = {v1_imm[DATA_WIDTH-1:1], 1'b0};
                nxt_jump = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                nxt_jump = cond;
                nxt_tgt  = cond ? pc_imm : pc4;
            end
            OP_ADDI, OP_ADD:   nxt_res = V1_from_rs + b;
            OP_SUB:            nxt_res = V1_from_rs - b;
            OP_SLTI, OP_SLT:   nxt_res = {{(DATA_WIDTH-1){1'b0}}, $signed(V1_from_rs) < $signed(b)};
            OP_SLTIU, OP_SLTU: nxt_res = {{(DATA_WIDTH-1){1'b0}}, V1_from_rs < b};
            OP_XORI, OP_XOR:   nxt_res = V1_from_rs ^ b;
            OP_ORI, OP_OR:     nxt_res = V1_from_rs | b;
            OP_ANDI, OP_AND:   nxt_res = V1_from_rs & b;
            OP_SLLI, OP_SLL:   nxt_res = V1_from_rs << sh;
            OP_SRLI, OP_SRL:   nxt_res = V1_from_rs >> sh;
            OP_SRAI, OP_SRA:   nxt_res = DATA_WIDTH'($signed(V1_from_rs) >>> sh);
            default:           nxt_valid = 1'b0;
        endcase
    end
    // CDB register: flush beats freeze, freeze holds everything including valid
    always_ff @(posedge clk) begin
        if (rst || misbranch_flag) begin
            valid_to_cdb     <= 1'b0;
            rob_id_to_cdb    <= '0;
            result_to_cdb    <= '0;
            target_pc_to_cdb <= '0;
            jump_flag_to_cdb <= 1'b0;
        end else if (rdy) begin
            valid_to_cdb     <= nxt_valid;
            rob_id_to_cdb    <= nxt_valid ? rob_id_from_rs : '0;
            result_to_cdb    <= nxt_res;
            target_pc_to_cdb <= nxt_tgt;
            jump_flag_to_cdb <= nxt_jump;
        end
    end
endmodule

// File: tb/tb_arith_unit_alu.sv
// tb_arith_unit_alu: directed vectors with a behavioural CDB model checked every cycle
module tb_arith_unit_alu;
    import arith_unit_alu_pkg::*;
    typedef struct packed {
        logic        valid;
        logic        chk;
        logic [4:0]  id;
        logic [31:0] res;
        logic [31:0] tgt;
        logic        jump;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        misb = 1'b0;
    openum_t     op = OP_NOP;
    logic [31:0] v1 = '0, v2 = '0, pc = '0, imm = '0;
    logic [4:0]  id = '0;
    logic        valid_to_cdb, jump_flag_to_cdb;
    logic [4:0]  rob_id_to_cdb;
    logic [31:0] result_to_cdb, target_pc_to_cdb;
    exp_t        exp_q;
    logic        known = 1'b0;
    int          checks = 0;
    int          errors = 0;
    arith_unit_alu dut (
        .clk(clk), .rst(rst), .rdy(rdy), .openum_from_rs(op),
        .V1_from_rs(v1), .V2_from_rs(v2), .pc_from_rs(pc), .imm_from_rs(imm),
        .rob_id_from_rs(id), .misbranch_flag(misb),
        .valid_to_cdb(valid_to_cdb), .rob_id_to_cdb(rob_id_to_cdb),
        .result_to_cdb(result_to_cdb), .target_pc_to_cdb(target_pc_to_cdb),
        .jump_flag_to_cdb(jump_flag_to_cdb)
    );
    always #5 clk = ~clk;
    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, act, req, $time);
        end
    endtask
    // what the spec says the CDB must carry for one issued op
    function automatic exp_t model(openum_t o, logic [31:0] a, logic [31:0] b, logic [31:0] p, logic [31:0] i, logic [4:0] t);
        exp_t e;
        int sa, sb, si;
        logic taken;
        sa = a; sb = b; si = i;
        e = '{valid: 1'b1, chk: 1'b1, id: t, res: 32'd0, tgt: 32'd0, jump: 1'b0};
        taken = 1'b0;
        case (o)
            OP_LUI:   e.res = i;
            OP_AUIPC: e.res = p + i;
            OP_JAL:   begin e.res = p + 4; e.tgt = p + i; e.jump = 1'b1; end
            OP_JALR:  begin e.res = p + 4; e.tgt = (a + i) - ((a + i) % 2); e.jump = 1'b1; end
            OP_ADD:   e.res = a + b;
            OP_ADDI:  e.res = a + i;
            OP_SUB:   e.res = a - b;
            OP_SLT:   e.res = (sa < sb) ? 1 : 0;
            OP_SLTI:  e.res = (sa < si) ? 1 : 0;
            OP_SLTU:  e.res = (a < b) ? 1 : 0;
            OP_SLTIU: e.res = (a < i) ? 1 : 0;
            OP_XOR:   e.res = a ^ b;
            OP_XORI:  e.res = a ^ i;
            OP_OR:    e.res = a | b;
            OP_ORI:   e.res = a | i;
            OP_AND:   e.res = a & b;
            OP_ANDI:  e.res = a & i;
            OP_SLL:   e.res = a << (b % 32);
            OP_SLLI:  e.res = a << (i % 32);
            OP_SRL:   e.res = a >> (b % 32);
            OP_SRLI:  e.res = a >> (i % 32);
            OP_SRA:   e.res = sa >>> (b % 32);
            OP_SRAI:  e.res = sa >>> (i % 32);
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                if (o == OP_BEQ)  taken = a == b;
                if (o == OP_BNE)  taken = a != b;
                if (o == OP_BLT)  taken = sa < sb;
                if (o == OP_BGE)  taken = sa >= sb;
                if (o == OP_BLTU) taken = a < b;
                if (o == OP_BGEU) taken = a >= b;
                e.jump = taken;
                e.tgt = taken ? p + i : p + 4;
            end
            default: e = '0;
        endcase
        return e;
    endfunction
    // model register mirrors the unit's clocking priorities
    always @(posedge clk) begin
        if (rst || misb) begin
            exp_q <= '{valid: 1'b0, chk: 1'b1, id: 5'd0, res: 32'd0, tgt: 32'd0, jump: 1'b0};
            known <= 1'b1;
        end else if (rdy) exp_q <= model(op, v1, v2, pc, imm, id);
    end
    // compare the CDB to the model on every falling edge
    always @(negedge clk) begin
        if (known) begin
            check("valid", valid_to_cdb, exp_q.valid);
            check("jump", jump_flag_to_cdb, exp_q.jump);
            if (exp_q.chk) begin
                check("tag", rob_id_to_cdb, exp_q.id);
                check("result", result_to_cdb, exp_q.res);
                check("target", target_pc_to_cdb, exp_q.tgt);
            end
        end
    end
    task automatic issue(input openum_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i, input logic [4:0] t);
        op = o; v1 = a; v2 = b; pc = p; imm = i; id = t;
        @(posedge clk);
        #1;
    endtask
    task automatic lit(input string n, input logic v, input logic [4:0] t, input logic [31:0] r,
                       input logic [31:0] g, input logic j);
        check({n, ".valid"}, valid_to_cdb, v);
        check({n, ".tag"}, rob_id_to_cdb, t);
        check({n, ".result"}, result_to_cdb, r);
        check({n, ".target"}, target_pc_to_cdb, g);
        check({n, ".jump"}, jump_flag_to_cdb, j);
    endtask
    logic [31:0] va [4] = '{32'd7, 32'h8000_0000, 32'd5, 32'hFFFF_FFFD};
    logic [31:0] vb [4] = '{32'hFFFF_FFFF, 32'd33, 32'd5, 32'h7FFF_FFFF};
    logic [31:0] vi [4] = '{32'hFFFF_FFF8, 32'd3, 32'h0000_0805, 32'hFFFF_F000};
    logic [31:0] vp [4] = '{32'h100, 32'hFFFF_FFFC, 32'h40, 32'h8000_0000};
    initial begin
        issue(OP_NOP, 0, 0, 0, 0, 0);
        issue(OP_ADD, 1, 1, 0, 0, 7);
        rst = 1'b0;
        lit("reset", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        issue(OP_ADD, 32'd7, 32'hFFFF_FFFF, 0, 0, 5'd3);
        lit("add", 1'b1, 5'd3, 32'd6, 32'd0, 1'b0);
        issue(OP_NOP, 0, 0, 0, 0, 0);
        check("add.drop", valid_to_cdb, 1'b0);
        issue(OP_SUB, 32'd5, 32'd9, 0, 0, 5'd1);
        check("sub", result_to_cdb, 32'hFFFF_FFFC);
        issue(OP_SRA, 32'h8000_0000, 32'd33, 0, 0, 5'd2);
        check("sra", result_to_cdb, 32'hC000_0000);
        check("sra.tag", rob_id_to_cdb, 5'd2);
        issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 0, 0, 5'd4);
        check("sltu", result_to_cdb, 32'd1);
        check("sltu.tag", rob_id_to_cdb, 5'd4);
        issue(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'hFFFF_FFF8, 5'd5);
        lit("blt", 1'b1, 5'd5, 32'd0, 32'hF8, 1'b1);
        issue(OP_BGEU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'hFFFF_FFF8, 5'd6);
        lit("bgeu", 1'b1, 5'd6, 32'd0, 32'hF8, 1'b1);
        issue(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'hFFFF_FFF8, 5'd7);
        lit("bltu", 1'b1, 5'd7, 32'd0, 32'h104, 1'b0);
        issue(OP_JALR, 32'h1003, 0, 32'h40, 32'd2, 5'd8);
        lit("jalr", 1'b1, 5'd8, 32'h44, 32'h1004, 1'b1);
        issue(OP_JAL, 0, 0, 32'hFFFF_FFFC, 32'h10, 5'd9);
        lit("jal.wrap", 1'b1, 5'd9, 32'd0, 32'hC, 1'b1);
        issue(OP_ADD, 32'd2, 32'd2, 0, 0, 5'd10);
        check("preflush.valid", valid_to_cdb, 1'b1);
        misb = 1'b1;
        issue(OP_ADD, 32'd3, 32'd3, 0, 0, 5'd11);
        misb = 1'b0;
        lit("flush", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        issue(OP_ADD, 32'd1, 32'd2, 0, 0, 5'd5);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(OP_ADD, 32'd10, 32'd10, 0, 0, 5'd6);
            lit("hold", 1'b1, 5'd5, 32'd3, 32'd0, 1'b0);
        end
        rdy = 1'b1;
        issue(OP_ADD, 32'd10, 32'd10, 0, 0, 5'd6);
        lit("resume", 1'b1, 5'd6, 32'd20, 32'd0, 1'b0);
        rdy = 1'b0;
        rst = 1'b1;
        issue(OP_ADD, 32'd10, 32'd10, 0, 0, 5'd6);
        lit("rst_frozen", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
        rdy = 1'b1;
        for (int k = 1; k <= 29; k++)
            for (int s = 0; s < 4; s++)
                issue(openum_t'(k), va[s], vb[(s + k) % 4], vp[s], vi[(s + 2 * k) % 4], 5'((k * 4 + s) % 31 + 1));
        issue(openum_t'(6'd40), 32'd1, 32'd1, 32'd0, 32'd0, 5'd3);
        check("unknown.valid", valid_to_cdb, 1'b0);
        issue(OP_NOP, 0, 0, 0, 0, 0);
        issue(OP_NOP, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
